// File: rtl/pool_window_if.sv
// Stream-side bundle for pool_window_gen: a raster pixel input and a window output.
// Every channel is valid/ready: a transfer happens on a rising edge where valid && ready are both 1,
// and a source holding valid=1 keeps its payload stable until that transfer.
interface pool_window_if #(
   parameter int N     = 2,
   parameter int WIDTH = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [N*N*WIDTH-1:0]   out_window;
   logic                   out_last;

   // master is the surrounding system (pixel source + window sink), slave is the window generator
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_window, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_window, out_last
   );
endinterface

// File: rtl/pool_window_gen.sv
// Raster pixel stream to non-overlapping NxN window assembler (stride N) for max_pooling.
// Element (r,c) of a window sits at out_window[(r*N+c)*WIDTH +: WIDTH].
module pool_window_gen #(
   parameter int POOLING_NxN = 2,
   parameter int WIDTH       = 8,
   parameter int IMG_W       = 8,
   parameter int IMG_H       = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   pool_window_if.slave  bus
);

   localparam int N        = POOLING_NxN;
   localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int SW       = $clog2(N);
   localparam int LB_DEPTH = (N - 1) * IMG_W;
   localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam int OW       = N * N * WIDTH;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [SW-1:0] SUB_LAST = SW'(N - 1);

   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [SW-1:0]    sub_c;
   logic [SW-1:0]    sub_r;

   logic             in_ready_w;
   logic             accept;
   logic             complete;
   logic             row_end;
   logic             frame_end;
   logic [LBW-1:0]   wr_idx;

   logic [WIDTH-1:0] lb [LB_DEPTH];
   logic [WIDTH-1:0] sr [N-1];
   logic [OW-1:0]    win_next;

   logic             out_valid_q;
   logic             out_last_q;
   logic [OW-1:0]    out_window_q;

   assign in_ready_w     = !out_valid_q || bus.out_ready;
   assign bus.in_ready   = in_ready_w;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_window = out_window_q;
   assign bus.out_last   = out_last_q;

   assign accept    = bus.in_valid && in_ready_w;
   assign complete  = accept && (sub_r == SUB_LAST) && (sub_c == SUB_LAST);
   assign row_end   = (col == COL_LAST);
   assign frame_end = row_end && (row == ROW_LAST);
   assign wr_idx    = LBW'(int'(sub_r) * IMG_W + int'(col));

   // sub_c/sub_r track col%N and row%N without a divider; they wrap with col/row
   // because the frame dimensions are multiples of N
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col   <= '0;
         row   <= '0;
         sub_c <= '0;
         sub_r <= '0;
      end else if (clear) begin
         col   <= '0;
         row   <= '0;
         sub_c <= '0;
         sub_r <= '0;
      end else if (accept) begin
         col   <= row_end ? '0 : col + 1'b1;
         sub_c <= (sub_c == SUB_LAST) ? '0 : sub_c + 1'b1;
         if (row_end) begin
            row   <= frame_end ? '0 : row + 1'b1;
            sub_r <= (sub_r == SUB_LAST) ? '0 : sub_r + 1'b1;
         end
      end
   end

   // Upper N-1 rows of a band go to the line buffer; the bottom row only needs
   // the last N-1 pixels of the current tile, kept in a short shift register.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (sub_r != SUB_LAST) begin
            lb[wr_idx] <= bus.in_data;
         end else begin
            for (int i = 0; i < N - 2; i++) begin
               sr[i] <= sr[i+1];
            end
            sr[N-2] <= bus.in_data;
         end
      end
   end

   always_comb begin
      win_next = '0;
      for (int r = 0; r < N - 1; r++) begin
         for (int c = 0; c < N; c++) begin
            win_next[(r*N+c)*WIDTH +: WIDTH] = lb[LBW'(r * IMG_W + int'(col) - (N - 1) + c)];
         end
      end
      for (int c = 0; c < N - 1; c++) begin
         win_next[((N-1)*N+c)*WIDTH +: WIDTH] = sr[c];
      end
      win_next[(N*N-1)*WIDTH +: WIDTH] = bus.in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_window_q <= '0;
      end else if (clear) begin
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_window_q <= '0;
      end else if (complete) begin
         out_valid_q  <= 1'b1;
         out_last_q   <= frame_end;
         out_window_q <= win_next;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_q  <= 1'b0;
      end
   end

endmodule
